sad_thread_engine: RTL and testbench

//  Execution end of the SAD thread command path: consumes decoded SAD commands
//  (SADsignal=1 "SAD calculation" from sb, SADsignal=0 "loadSAD" from lb).
//  A SAD command streams one candidate block of current/reference pixels,

---
 rtl/vbsme_pkg.sv | 20 ++
 rtl/sad_lane_sum.sv | 27 ++
 rtl/sad_thread_engine.sv | 150 +++++++++++++++
 tb/tb_sad_thread_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vbsme_pkg.sv
// Shared definitions for the VBSME SAD thread path: FSM states, SADsignal
// command encodings and the default pixel geometry.
package vbsme_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2,
    LOAD   = 2'd3
  } state_e;

  localparam logic SAD_CALC = 1'b1;
  localparam logic SAD_LOAD = 1'b0;

  localparam int DEF_PIX_W        = 8;
  localparam int DEF_LANES        = 4;
  localparam int DEF_BLOCK_PIXELS = 16;
  localparam int DEF_IDX_W        = 10;

endpackage

// File: rtl/sad_lane_sum.sv
// Combinational per-beat SAD: absolute difference on every lane, summed.
// Operands are unsigned, so the sum of LANES diffs fits PIX_W+clog2(LANES).
module sad_lane_sum #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int SUM_W = PIX_W + $clog2(LANES)
) (
  input  logic [LANES*PIX_W-1:0] cur_pix_i,
  input  logic [LANES*PIX_W-1:0] ref_pix_i,
  output logic [SUM_W-1:0]       sum_o
);

  logic [PIX_W-1:0] diff [LANES];

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (cur_pix_i[l*PIX_W +: PIX_W] >= ref_pix_i[l*PIX_W +: PIX_W]) begin
        diff[l] = cur_pix_i[l*PIX_W +: PIX_W] - ref_pix_i[l*PIX_W +: PIX_W];
      end else begin
        diff[l] = ref_pix_i[l*PIX_W +: PIX_W] - cur_pix_i[l*PIX_W +: PIX_W];
      end
      sum_o = sum_o + SUM_W'(diff[l]);
    end
  end

endmodule

// File: rtl/sad_thread_engine.sv
// SAD thread execution engine: streams candidate blocks, returns each block SAD,
// tracks the running minimum and hands it back (then clears) on loadSAD.
module sad_thread_engine
  import vbsme_pkg::*;
#(
  parameter int PIX_W        = DEF_PIX_W,
  parameter int LANES        = DEF_LANES,
  parameter int BLOCK_PIXELS = DEF_BLOCK_PIXELS,
  parameter int IDX_W        = DEF_IDX_W,
  parameter int SAD_W        = PIX_W + $clog2(BLOCK_PIXELS)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   cmd_valid,
  input  logic                   SADsignal,
  output logic                   cmd_ready,
  input  logic                   pix_valid,
  input  logic [LANES*PIX_W-1:0] cur_pix,
  input  logic [LANES*PIX_W-1:0] ref_pix,
  output logic                   pix_ready,
  output logic                   sad_valid,
  output logic [SAD_W-1:0]       sad_out,
  output logic [IDX_W-1:0]       sad_idx,
  input  logic                   sad_ready,
  output logic                   busy,
  output state_e                 dbg_state_o
);

  // All three interfaces use valid/ready: a transfer happens on the rising edge
  // where both are high; ready depends only on the current state (never on
  // valid), and a presented result holds sad_out/sad_idx until it transfers.

  localparam int BEATS  = BLOCK_PIXELS / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSUM_W = PIX_W + $clog2(LANES);

  state_e             state_q, state_d;
  logic [SAD_W-1:0]   acc_q, acc_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   cand_cnt_q, cand_cnt_d;
  logic [SAD_W-1:0]   min_sad_q, min_sad_d;
  logic [IDX_W-1:0]   min_idx_q, min_idx_d;
  logic [SAD_W-1:0]   sad_out_q, sad_out_d;
  logic [IDX_W-1:0]   sad_idx_q, sad_idx_d;

  logic [LSUM_W-1:0]  lane_sum;
  logic [SAD_W-1:0]   acc_sum;
  logic               last_beat;

  sad_lane_sum #(
    .PIX_W (PIX_W),
    .LANES (LANES),
    .SUM_W (LSUM_W)
  ) u_lane_sum (
    .cur_pix_i (cur_pix),
    .ref_pix_i (ref_pix),
    .sum_o     (lane_sum)
  );

  assign acc_sum   = acc_q + SAD_W'(lane_sum);
  assign last_beat = (beat_cnt_q == BEAT_W'(BEATS - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      cand_cnt_q <= '0;
      min_sad_q  <= '1;
      min_idx_q  <= '0;
      sad_out_q  <= '0;
      sad_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      min_sad_q  <= min_sad_d;
      min_idx_q  <= min_idx_d;
      sad_out_q  <= sad_out_d;
      sad_idx_q  <= sad_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    cand_cnt_d = cand_cnt_q;
    min_sad_d  = min_sad_q;
    min_idx_d  = min_idx_q;
    sad_out_d  = sad_out_q;
    sad_idx_d  = sad_idx_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (SADsignal == SAD_CALC) begin
            state_d    = ACCUM;
            acc_d      = '0;
            beat_cnt_d = '0;
          end else begin
            state_d   = LOAD;
            sad_out_d = min_sad_q;
            sad_idx_d = min_idx_q;
          end
        end
      end
      ACCUM: begin
        if (pix_valid) begin
          acc_d      = acc_sum;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            // Result and minimum are captured together so the candidate index
            // presented is the pre-increment count.
            state_d    = RESULT;
            sad_out_d  = acc_sum;
            sad_idx_d  = cand_cnt_q;
            cand_cnt_d = cand_cnt_q + 1'b1;
            if (acc_sum < min_sad_q) begin
              min_sad_d = acc_sum;
              min_idx_d = cand_cnt_q;
            end
          end
        end
      end
      RESULT: begin
        if (sad_ready) state_d = IDLE;
      end
      LOAD: begin
        if (sad_ready) begin
          state_d    = IDLE;
          min_sad_d  = '1;
          min_idx_d  = '0;
          cand_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign pix_ready   = (state_q == ACCUM);
  assign sad_valid   = (state_q == RESULT) || (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign sad_out     = sad_out_q;
  assign sad_idx     = sad_idx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sad_thread_engine.sv
// Self-checking bench for sad_thread_engine: directed and random SAD blocks
// compared with a pixel-array reference model of SAD and minimum search.
module tb_sad_thread_engine;
  import vbsme_pkg::*;

  localparam int PIX_W = 8;
  localparam int LANES = 4;
  localparam int BLK   = 16;
  localparam int IDX_W = 10;
  localparam int SAD_W = 12;
  localparam int BEATS = BLK / LANES;
  localparam int ALL1  = (1 << SAD_W) - 1;

  logic                   Clk = 1'b0;
  logic                   Rst = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   SADsignal = 1'b0;
  logic                   cmd_ready;
  logic                   pix_valid = 1'b0;
  logic [LANES*PIX_W-1:0] cur_pix = '0;
  logic [LANES*PIX_W-1:0] ref_pix = '0;
  logic                   pix_ready;
  logic                   sad_valid;
  logic [SAD_W-1:0]       sad_out;
  logic [IDX_W-1:0]       sad_idx;
  logic                   sad_ready = 1'b0;
  logic                   busy;
  state_e                 dbg_state;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_min, m_idx, m_cand;
  logic [7:0] cur_blk [BLK];
  logic [7:0] ref_blk [BLK];

  sad_thread_engine dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .cmd_valid   (cmd_valid),
    .SADsignal   (SADsignal),
    .cmd_ready   (cmd_ready),
    .pix_valid   (pix_valid),
    .cur_pix     (cur_pix),
    .ref_pix     (ref_pix),
    .pix_ready   (pix_ready),
    .sad_valid   (sad_valid),
    .sad_out     (sad_out),
    .sad_idx     (sad_idx),
    .sad_ready   (sad_ready),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int block_sad();
    int s = 0;
    for (int p = 0; p < BLK; p++) begin
      int a = int'(cur_blk[p]);
      int b = int'(ref_blk[p]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_min = ALL1;
    m_idx = 0;
    m_cand = 0;
  endtask

  task automatic fill_const(input logic [7:0] c, input logic [7:0] r);
    for (int p = 0; p < BLK; p++) begin
      cur_blk[p] = c;
      ref_blk[p] = r;
    end
  endtask

  task automatic fill_rand();
    for (int p = 0; p < BLK; p++) begin
      cur_blk[p] = 8'($urandom_range(0, 255));
      ref_blk[p] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_cmd(input logic sig);
    int n = 0;
    cmd_valid = 1'b1;
    SADsignal = sig;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_accept_wait", 32'(n < 100), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input int b);
    for (int l = 0; l < LANES; l++) begin
      cur_pix[l*PIX_W +: PIX_W] = cur_blk[b*LANES + l];
      ref_pix[l*PIX_W +: PIX_W] = ref_blk[b*LANES + l];
    end
  endtask

  // Holds the result for bp cycles (optionally poking a command and stray
  // pixels), then completes the handshake and checks return to idle.
  task automatic hold_and_take(input int bp, input bit poke, input int e_sad, input int e_idx);
    for (int c = 0; c < bp; c++) begin
      sad_ready = 1'b0;
      cmd_valid = poke;
      SADsignal = SAD_LOAD;
      pix_valid = 1'b1;
      cur_pix   = 32'($urandom);
      ref_pix   = 32'($urandom);
      tick();
      check("bp_sad_out", 32'(sad_out), 32'(e_sad));
      check("bp_sad_idx", 32'(sad_idx), 32'(e_idx));
      check("bp_sad_valid", 32'(sad_valid), 32'd1);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_pix_ready", 32'(pix_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    pix_valid = 1'b0;
    sad_ready = 1'b1;
    tick();
    sad_ready = 1'b0;
    check("done_sad_valid", 32'(sad_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_sad(input int max_gap, input int bp, input bit poke);
    int e_sad = block_sad();
    int e_idx = m_cand;
    if (e_sad < m_min) begin
      m_min = e_sad;
      m_idx = m_cand;
    end
    m_cand = (m_cand + 1) % (1 << IDX_W);
    send_cmd(SAD_CALC);
    for (int b = 0; b < BEATS; b++) begin
      int gap = $urandom_range(0, max_gap);
      pix_valid = 1'b0;
      repeat (gap) begin
        tick();
        check("gap_sad_valid", 32'(sad_valid), 32'd0);
      end
      pix_valid = 1'b1;
      drive_beat(b);
      check("accum_pix_ready", 32'(pix_ready), 32'd1);
      tick();
    end
    pix_valid = 1'b0;
    check("res_sad_valid", 32'(sad_valid), 32'd1);
    check("res_sad_out", 32'(sad_out), 32'(e_sad));
    check("res_sad_idx", 32'(sad_idx), 32'(e_idx));
    hold_and_take(bp, poke, e_sad, e_idx);
  endtask

  task automatic run_load(input int bp);
    send_cmd(SAD_LOAD);
    check("load_sad_valid", 32'(sad_valid), 32'd1);
    check("load_sad_out", 32'(sad_out), 32'(m_min));
    check("load_sad_idx", 32'(sad_idx), 32'(m_idx));
    hold_and_take(bp, 1'b0, m_min, m_idx);
    model_reset();
  endtask

  initial begin
    model_reset();
    // Reset and idle values
    repeat (2) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_sad_valid", 32'(sad_valid), 32'd0);
    Rst = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_pix_ready", 32'(pix_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sad_out", 32'(sad_out), 32'd0);

    // Reset asserted mid-ACCUM takes effect without a clock edge
    fill_const(8'h33, 8'h11);
    send_cmd(SAD_CALC);
    pix_valid = 1'b1;
    drive_beat(0);
    tick();
    drive_beat(1);
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    Rst = 1'b0;
    #1;
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_pix_ready", 32'(pix_ready), 32'd0);
    check("arst_sad_valid", 32'(sad_valid), 32'd0);
    check("arst_sad_out", 32'(sad_out), 32'd0);
    check("arst_sad_idx", 32'(sad_idx), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    pix_valid = 1'b0;
    tick();
    Rst = 1'b1;
    model_reset();
    tick();

    // Basic block: diff 4 on all 16 pixels
    fill_const(8'h10, 8'h0C);
    check("model_basic", 32'(block_sad()), 32'd64);
    run_sad(0, 0, 1'b0);
    run_load(0);

    // Minimum tracking with a tie: 64, 20, 20 -> min 20 at index 1
    fill_const(8'h10, 8'h0C);
    run_sad(0, 0, 1'b0);
    fill_const(8'h40, 8'h40);
    for (int l = 0; l < LANES; l++) cur_blk[l] = 8'h45;
    run_sad(0, 0, 1'b0);
    run_sad(0, 0, 1'b0);
    check("model_tie_idx", 32'(m_idx), 32'd1);
    run_load(0);
    run_load(0);

    // Extreme pixel values
    fill_const(8'hFF, 8'h00);
    run_sad(0, 2, 1'b0);

    // Random blocks with stalls, backpressure and commands offered during RESULT
    for (int t = 0; t < 12; t++) begin
      fill_rand();
      run_sad(3, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    fill_rand();
    run_sad(2, 5, 1'b1);
    run_load(5);

    // Candidate index wraps after 2^IDX_W blocks
    for (int t = 0; t < (1 << IDX_W); t++) begin
      fill_rand();
      run_sad(0, 0, 1'b0);
    end
    check("model_wrap_cand", 32'(m_cand), 32'd0);
    fill_const(8'h00, 8'h00);
    run_sad(1, 1, 1'b0);
    run_load(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
